// File: rtl/bp_serial_link_mux_if.sv
// Bundle of the parallel channel ports and both link halves of bp_serial_link_mux.
// The slave modport is the mux's own view; master is the view of whatever drives it.
interface bp_serial_link_mux_if #(
    parameter int data_width_p = 32,
    parameter int link_width_p = 8,
    parameter int els_p        = 3
);
    logic [els_p-1:0]                   valid_i;
    logic [els_p-1:0][data_width_p-1:0] data_i;
    logic [els_p-1:0]                   ready_o;

    logic                               link_v_o;
    logic [link_width_p-1:0]            link_data_o;
    logic                               link_ready_i;

    logic                               link_v_i;
    logic [link_width_p-1:0]            link_data_i;
    logic                               link_ready_o;

    logic [els_p-1:0]                   valid_o;
    logic [els_p-1:0][data_width_p-1:0] data_o;
    logic [els_p-1:0]                   yumi_i;
    logic                               err_o;

    modport slave (
        input  valid_i, data_i, link_ready_i, link_v_i, link_data_i, yumi_i,
        output ready_o, link_v_o, link_data_o, link_ready_o, valid_o, data_o, err_o
    );

    modport master (
        output valid_i, data_i, link_ready_i, link_v_i, link_data_i, yumi_i,
        input  ready_o, link_v_o, link_data_o, link_ready_o, valid_o, data_o, err_o
    );
endinterface

// File: rtl/bp_serial_link_mux.sv
// Carries els_p parallel valid/ready channels over one narrow link.
// Tx: round-robin pick, one header flit (channel id) then num_flits_lp data flits,
// least-significant slice first. Rx: decode header, reassemble, deliver into a
// one-entry buffer per channel. A stalled last flit blocks the whole link on purpose.
// The id must fit in one flit: id_width_lp <= link_width_p.
module bp_serial_link_mux #(
    parameter int data_width_p = 32,
    parameter int link_width_p = 8,
    parameter int els_p        = 3
) (
    input  logic                clk_i,
    input  logic                reset_i,
    bp_serial_link_mux_if.slave io
);

    localparam int num_flits_lp = (data_width_p + link_width_p - 1) / link_width_p;
    localparam int id_width_lp  = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int flit_bits_lp = num_flits_lp * link_width_p;
    localparam int cnt_width_lp = (num_flits_lp > 1) ? $clog2(num_flits_lp) : 1;
    localparam logic [cnt_width_lp-1:0] last_cnt_lp = cnt_width_lp'(num_flits_lp - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_HDR, TX_BODY} tx_state_e;
    typedef enum logic       {RX_HDR, RX_BODY}          rx_state_e;

    // ---------------- transmit half ----------------
    tx_state_e                  tx_state_r, tx_state_n;
    logic [id_width_lp-1:0]     last_grant_r;
    logic [id_width_lp-1:0]     tx_id_r;
    logic [flit_bits_lp-1:0]    tx_buf_r;
    logic [cnt_width_lp-1:0]    tx_cnt_r;

    logic [id_width_lp-1:0]     grant;
    logic                       grant_v;
    logic [data_width_p-1:0]    grant_data;

    logic [els_p-1:0]           tx_ready;
    logic                       tx_v;
    logic [link_width_p-1:0]    tx_data;

    // Round-robin pick: first requester above last_grant, else first from channel 0 upward.
    always_comb begin
        grant      = '0;
        grant_v    = 1'b0;
        grant_data = '0;
        for (int j = 0; j < els_p; j++) begin
            if (!grant_v && io.valid_i[j] && (id_width_lp'(j) > last_grant_r)) begin
                grant   = id_width_lp'(j);
                grant_v = 1'b1;
            end
        end
        for (int j = 0; j < els_p; j++) begin
            if (!grant_v && io.valid_i[j] && (id_width_lp'(j) <= last_grant_r)) begin
                grant   = id_width_lp'(j);
                grant_v = 1'b1;
            end
        end
        for (int j = 0; j < els_p; j++) begin
            if (grant == id_width_lp'(j)) begin
                grant_data = io.data_i[j];
            end
        end
    end

    // Tx state register.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            tx_state_r <= TX_IDLE;
        end else begin
            tx_state_r <= tx_state_n;
        end
    end

    // Tx next state: any grant starts a message; the link handshake advances it.
    always_comb begin
        tx_state_n = tx_state_r;
        case (tx_state_r)
            TX_IDLE: if (grant_v) tx_state_n = TX_HDR;
            TX_HDR:  if (io.link_ready_i) tx_state_n = TX_BODY;
            TX_BODY: if (io.link_ready_i && (tx_cnt_r == last_cnt_lp)) tx_state_n = TX_IDLE;
            default: tx_state_n = TX_IDLE;
        endcase
    end

    // Tx datapath: capture the granted payload, then shift one slice out per accepted flit.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            last_grant_r <= id_width_lp'(els_p - 1);
            tx_id_r      <= '0;
            tx_buf_r     <= '0;
            tx_cnt_r     <= '0;
        end else begin
            case (tx_state_r)
                TX_IDLE: begin
                    if (grant_v) begin
                        tx_buf_r     <= flit_bits_lp'(grant_data);
                        tx_id_r      <= grant;
                        last_grant_r <= grant;
                    end
                end
                TX_HDR: begin
                    if (io.link_ready_i) begin
                        tx_cnt_r <= '0;
                    end
                end
                TX_BODY: begin
                    if (io.link_ready_i) begin
                        tx_cnt_r <= tx_cnt_r + 1'b1;
                        tx_buf_r <= tx_buf_r >> link_width_p;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Tx outputs: ready only to the granted channel in idle; the flit comes straight from registers so it holds under stall.
    always_comb begin
        tx_ready = '0;
        tx_v     = 1'b0;
        tx_data  = '0;
        case (tx_state_r)
            TX_IDLE: begin
                for (int j = 0; j < els_p; j++) begin
                    tx_ready[j] = grant_v && (grant == id_width_lp'(j));
                end
            end
            TX_HDR: begin
                tx_v    = 1'b1;
                tx_data = link_width_p'(tx_id_r);
            end
            TX_BODY: begin
                tx_v    = 1'b1;
                tx_data = tx_buf_r[link_width_p-1:0];
            end
            default: begin
            end
        endcase
        if (!reset_i) begin
            tx_ready = '0;
        end
    end

    assign io.ready_o     = tx_ready;
    assign io.link_v_o    = tx_v;
    assign io.link_data_o = tx_data;

    // ---------------- receive half ----------------
    rx_state_e                          rx_state_r, rx_state_n;
    logic [id_width_lp-1:0]             rx_id_r;
    logic                               rx_drop_r;
    logic [cnt_width_lp-1:0]            rx_cnt_r;
    logic [flit_bits_lp-1:0]            rx_asm_r;
    logic                               err_r;
    logic [els_p-1:0]                   valid_r;
    logic [els_p-1:0][data_width_p-1:0] data_r;

    logic [id_width_lp-1:0]             hdr_id;
    logic                               hdr_bad;
    logic                               rx_last;
    logic                               dest_busy;
    logic                               rx_ready;
    logic                               rx_fire;
    logic [flit_bits_lp-1:0]            asm_next;

    assign hdr_id   = io.link_data_i[id_width_lp-1:0];
    assign hdr_bad  = (32'(hdr_id) >= 32'(els_p));
    assign rx_last  = (rx_state_r == RX_BODY) && (rx_cnt_r == last_cnt_lp);
    assign rx_fire  = io.link_v_i && rx_ready;
    assign asm_next = (rx_asm_r >> link_width_p)
                    | (flit_bits_lp'(io.link_data_i) << (flit_bits_lp - link_width_p));

    // Destination buffer is busy if it holds data that is not being consumed this cycle.
    always_comb begin
        dest_busy = 1'b0;
        for (int j = 0; j < els_p; j++) begin
            if (rx_id_r == id_width_lp'(j)) begin
                dest_busy = valid_r[j] && !io.yumi_i[j];
            end
        end
    end

    // Rx state register.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            rx_state_r <= RX_HDR;
        end else begin
            rx_state_r <= rx_state_n;
        end
    end

    // Rx next state: a header opens a message, acceptance of the last flit closes it.
    always_comb begin
        rx_state_n = rx_state_r;
        case (rx_state_r)
            RX_HDR:  if (io.link_v_i) rx_state_n = RX_BODY;
            RX_BODY: if (rx_fire && rx_last) rx_state_n = RX_HDR;
            default: rx_state_n = RX_HDR;
        endcase
    end

    // Rx ready: always open except a last flit whose buffer is still full (head-of-line block).
    always_comb begin
        rx_ready = 1'b0;
        case (rx_state_r)
            RX_HDR:  rx_ready = 1'b1;
            RX_BODY: rx_ready = rx_last ? (rx_drop_r || !dest_busy) : 1'b1;
            default: rx_ready = 1'b0;
        endcase
        if (!reset_i) begin
            rx_ready = 1'b0;
        end
    end

    // Rx datapath: latch id and drop flag from the header, shift body flits in from the top.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            rx_id_r   <= '0;
            rx_drop_r <= 1'b0;
            rx_cnt_r  <= '0;
            rx_asm_r  <= '0;
            err_r     <= 1'b0;
        end else begin
            case (rx_state_r)
                RX_HDR: begin
                    if (io.link_v_i) begin
                        rx_id_r   <= hdr_id;
                        rx_drop_r <= hdr_bad;
                        rx_cnt_r  <= '0;
                        if (hdr_bad) begin
                            err_r <= 1'b1;
                        end
                    end
                end
                RX_BODY: begin
                    if (rx_fire) begin
                        rx_asm_r <= asm_next;
                        rx_cnt_r <= rx_cnt_r + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output buffers: a refill wins over a same-cycle yumi so valid stays up with new data.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            valid_r <= '0;
            data_r  <= '0;
        end else begin
            for (int j = 0; j < els_p; j++) begin
                if (rx_fire && rx_last && !rx_drop_r && (rx_id_r == id_width_lp'(j))) begin
                    valid_r[j] <= 1'b1;
                    data_r[j]  <= asm_next[data_width_p-1:0];
                end else if (io.yumi_i[j]) begin
                    valid_r[j] <= 1'b0;
                end
            end
        end
    end

    assign io.link_ready_o = rx_ready;
    assign io.valid_o      = valid_r;
    assign io.data_o       = data_r;
    assign io.err_o        = err_r;

endmodule

// File: tb/tb_bp_serial_link_mux.sv
// Bench for bp_serial_link_mux: 32-bit payload, 8-bit link, 3 channels, tx looped to rx.
// Delivered payloads are checked against a scoreboard filled from accepted inputs.
module tb_bp_serial_link_mux;

    localparam int DW = 32;
    localparam int LW = 8;
    localparam int NE = 3;

    typedef struct packed {
        logic [1:0]  ch;
        logic [31:0] data;
    } sb_t;

    logic clk = 1'b0;
    logic rst_n;
    logic loop_en;
    logic stall;
    logic inj_v;
    logic [LW-1:0] inj_d;
    logic [NE-1:0] yumi_en;

    sb_t sbq[$];
    int  checks   = 0;
    int  failures = 0;

    always #5 clk = ~clk;

    bp_serial_link_mux_if #(.data_width_p(DW), .link_width_p(LW), .els_p(NE)) lnk ();

    bp_serial_link_mux #(.data_width_p(DW), .link_width_p(LW), .els_p(NE)) dut (
        .clk_i   (clk),
        .reset_i (rst_n),
        .io      (lnk.slave)
    );

    // Loopback with an optional stall on both sides of the link, or direct rx injection.
    assign lnk.link_v_i     = loop_en ? (lnk.link_v_o & ~stall) : inj_v;
    assign lnk.link_data_i  = loop_en ? lnk.link_data_o : inj_d;
    assign lnk.link_ready_i = loop_en & lnk.link_ready_o & ~stall;
    assign lnk.yumi_i       = lnk.valid_o & yumi_en;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Present a payload on one channel and hold it until accepted; returns one cycle after acceptance.
    task automatic applyStimulus(input int ch, input logic [31:0] d);
        bit got;
        got = 1'b0;
        nextCycle();
        lnk.valid_i[ch] = 1'b1;
        lnk.data_i[ch]  = d;
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge clk);
            if (lnk.ready_o[ch]) got = 1'b1;
        end
        checkOutput($sformatf("accept_ch%0d", ch), 64'(got), 64'd1);
        nextCycle();
        lnk.valid_i[ch] = 1'b0;
    endtask

    task automatic waitDrain(input string tag);
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 64'(sbq.size()), 64'd0);
    endtask

    // Scoreboard: push on every input handshake, pop and compare on every consume.
    always @(negedge clk) begin
        sb_t e;
        int  idx;
        if (rst_n) begin
            for (int i = 0; i < NE; i++) begin
                if (lnk.valid_i[i] && lnk.ready_o[i]) begin
                    e.ch   = 2'(i);
                    e.data = lnk.data_i[i];
                    sbq.push_back(e);
                end
            end
            for (int i = 0; i < NE; i++) begin
                if (lnk.yumi_i[i]) begin
                    idx = -1;
                    for (int k = 0; k < sbq.size(); k++) begin
                        if (idx < 0 && sbq[k].ch == 2'(i)) idx = k;
                    end
                    checkOutput($sformatf("sb_expected_ch%0d", i), 64'(idx >= 0), 64'd1);
                    if (idx >= 0) begin
                        checkOutput($sformatf("sb_data_ch%0d", i), 64'(lnk.data_o[i]), 64'(sbq[idx].data));
                        sbq.delete(idx);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int grants;
        int cyc;
        int last_cyc;
        logic [7:0] exp_flits [5];
        logic [7:0] bad_flits [5];

        rst_n       = 1'b0;
        loop_en     = 1'b1;
        stall       = 1'b0;
        inj_v       = 1'b0;
        inj_d       = '0;
        yumi_en     = '1;
        lnk.valid_i = '0;
        lnk.data_i  = '0;

        // Reset values
        repeat (2) @(negedge clk);
        checkOutput("rst_ready_o", 64'(lnk.ready_o), 64'd0);
        checkOutput("rst_link_v_o", 64'(lnk.link_v_o), 64'd0);
        checkOutput("rst_link_ready_o", 64'(lnk.link_ready_o), 64'd0);
        checkOutput("rst_valid_o", 64'(lnk.valid_o), 64'd0);
        checkOutput("rst_err_o", 64'(lnk.err_o), 64'd0);
        nextCycle();
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_link_ready_o", 64'(lnk.link_ready_o), 64'd1);
        checkOutput("idle_link_v_o", 64'(lnk.link_v_o), 64'd0);

        // Round robin with all channels requesting
        $display("[TB] round robin");
        nextCycle();
        lnk.valid_i = '1;
        for (int j = 0; j < NE; j++) lnk.data_i[j] = {8'hA0 + 8'(j), 24'h0};
        grants   = 0;
        cyc      = 0;
        last_cyc = 0;
        while (grants < 6 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (lnk.ready_o != '0) begin
                checkOutput($sformatf("rr_grant%0d", grants), 64'(lnk.ready_o), 64'(1) << (grants % 3));
                if (grants > 0) checkOutput("rr_spacing", 64'(cyc - last_cyc), 64'd6);
                last_cyc = cyc;
                grants++;
                nextCycle();
                if (grants == 6) lnk.valid_i = '0;
                else for (int j = 0; j < NE; j++) lnk.data_i[j] = {8'hA0 + 8'(j), 24'(grants)};
            end
        end
        checkOutput("rr_count", 64'(grants), 64'd6);
        waitDrain("rr_drain");

        // Single message: exact flit sequence and latency
        $display("[TB] single message");
        exp_flits = '{8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        applyStimulus(1, 32'hDEADBEEF);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput($sformatf("single_v%0d", k), 64'(lnk.link_v_o), 64'd1);
            checkOutput($sformatf("single_flit%0d", k), 64'(lnk.link_data_o), 64'(exp_flits[k]));
            checkOutput($sformatf("single_nodeliver%0d", k), 64'(lnk.valid_o), 64'd0);
            nextCycle();
        end
        @(negedge clk);
        checkOutput("single_valid_o", 64'(lnk.valid_o), 64'b010);
        checkOutput("single_data_o", 64'(lnk.data_o[1]), 64'hDEADBEEF);
        checkOutput("single_tx_idle", 64'(lnk.link_v_o), 64'd0);
        waitDrain("single_drain");

        // Tx backpressure on the 0xBE flit
        $display("[TB] tx backpressure");
        applyStimulus(0, 32'hDEADBEEF);
        @(negedge clk);
        checkOutput("bp_hdr", 64'(lnk.link_data_o), 64'h00);
        nextCycle();
        @(negedge clk);
        checkOutput("bp_ef", 64'(lnk.link_data_o), 64'hEF);
        nextCycle();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput($sformatf("bp_hold%0d", k), 64'(lnk.link_data_o), 64'hBE);
            checkOutput($sformatf("bp_hold_v%0d", k), 64'(lnk.link_v_o), 64'd1);
            nextCycle();
        end
        stall = 1'b0;
        @(negedge clk);
        checkOutput("bp_be", 64'(lnk.link_data_o), 64'hBE);
        nextCycle();
        @(negedge clk);
        checkOutput("bp_ad", 64'(lnk.link_data_o), 64'hAD);
        nextCycle();
        @(negedge clk);
        checkOutput("bp_de", 64'(lnk.link_data_o), 64'hDE);
        checkOutput("bp_not_yet", 64'(lnk.valid_o), 64'd0);
        nextCycle();
        @(negedge clk);
        checkOutput("bp_valid_o", 64'(lnk.valid_o), 64'b001);
        checkOutput("bp_data_o", 64'(lnk.data_o[0]), 64'hDEADBEEF);
        waitDrain("bp_drain");

        // Rx full: second ch2 message blocks the link, queued ch0 waits behind it
        $display("[TB] rx full");
        yumi_en[2] = 1'b0;
        applyStimulus(2, 32'h22220001);
        repeat (5) nextCycle();
        @(negedge clk);
        checkOutput("full_first_valid", 64'(lnk.valid_o), 64'b100);
        nextCycle();
        applyStimulus(2, 32'h22220002);
        lnk.valid_i[0] = 1'b1;
        lnk.data_i[0]  = 32'h00000C0C;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checkOutput($sformatf("full_ch0_wait%0d", k), 64'(lnk.ready_o), 64'd0);
            nextCycle();
        end
        for (int k = 5; k <= 7; k++) begin
            @(negedge clk);
            checkOutput($sformatf("full_link_ready%0d", k), 64'(lnk.link_ready_o), 64'd0);
            checkOutput($sformatf("full_last_flit%0d", k), 64'(lnk.link_data_o), 64'h22);
            checkOutput($sformatf("full_old_data%0d", k), 64'(lnk.data_o[2]), 64'h22220001);
            checkOutput($sformatf("full_ch0_blocked%0d", k), 64'(lnk.ready_o), 64'd0);
            nextCycle();
        end
        yumi_en[2] = 1'b1;
        @(negedge clk);
        checkOutput("full_release", 64'(lnk.link_ready_o), 64'd1);
        nextCycle();
        @(negedge clk);
        checkOutput("full_refill_valid", 64'(lnk.valid_o[2]), 64'd1);
        checkOutput("full_refill_data", 64'(lnk.data_o[2]), 64'h22220002);
        checkOutput("full_ch0_granted", 64'(lnk.ready_o), 64'b001);
        nextCycle();
        lnk.valid_i[0] = 1'b0;
        waitDrain("full_drain");

        // Bad channel id injected directly on rx
        $display("[TB] bad id");
        bad_flits = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h44};
        nextCycle();
        loop_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) nextCycle();
            inj_v = 1'b1;
            inj_d = bad_flits[k];
            @(negedge clk);
            checkOutput($sformatf("bad_ready%0d", k), 64'(lnk.link_ready_o), 64'd1);
            checkOutput($sformatf("bad_err%0d", k), 64'(lnk.err_o), (k == 0) ? 64'd0 : 64'd1);
            checkOutput($sformatf("bad_novalid%0d", k), 64'(lnk.valid_o), 64'd0);
        end
        nextCycle();
        inj_v = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("bad_after_valid", 64'(lnk.valid_o), 64'd0);
            checkOutput("bad_after_err", 64'(lnk.err_o), 64'd1);
        end
        nextCycle();
        loop_en = 1'b1;
        applyStimulus(2, 32'h13572468);
        waitDrain("bad_recover_drain");
        checkOutput("bad_err_sticky", 64'(lnk.err_o), 64'd1);

        // Reset during the second data flit
        $display("[TB] reset mid-body");
        applyStimulus(0, 32'hA5A5A5A5);
        @(negedge clk);
        nextCycle();
        @(negedge clk);
        nextCycle();
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_link_v_o", 64'(lnk.link_v_o), 64'd0);
        checkOutput("mid_rst_link_ready_o", 64'(lnk.link_ready_o), 64'd0);
        checkOutput("mid_rst_valid_o", 64'(lnk.valid_o), 64'd0);
        checkOutput("mid_rst_ready_o", 64'(lnk.ready_o), 64'd0);
        checkOutput("mid_rst_err_o", 64'(lnk.err_o), 64'd0);
        sbq.delete();
        @(negedge clk);
        nextCycle();
        rst_n = 1'b1;
        applyStimulus(0, 32'h12345678);
        repeat (5) nextCycle();
        @(negedge clk);
        checkOutput("post_rst_valid_o", 64'(lnk.valid_o), 64'b001);
        checkOutput("post_rst_data_o", 64'(lnk.data_o[0]), 64'h12345678);
        waitDrain("post_rst_drain");

        checkOutput("sb_empty", 64'(sbq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bp_serial_link_mux.md
# bp_serial_link_mux

Multi-channel serializer/deserializer that carries `els_p` independent parallel valid/ready channels over a single shared narrow link. A round-robin arbiter selects a channel, and the transmit half sends one header flit carrying the channel id followed by `num_flits` data flits. The receive half decodes the header, reassembles the payload, and delivers it into a one-entry output buffer per channel. It sits at the ME boundary wherever several wide message streams must share one narrow wire bundle; tx and rx halves are exposed separately so they can be looped back or connected off-block.

## Interface

Parameters:
- `data_width_p`, "inv", width of each channel's parallel payload.
- `link_width_p`, "inv", width of one link flit.
- `els_p`, "inv", number of channels; must be ≥ 1.
- Localparam `num_flits_lp` = ceil(`data_width_p` / `link_width_p`).
- Localparam `id_width_lp` = max(1, clog2(`els_p`)); must be ≤ `link_width_p`.

Ports:
- `clk_i` in 1: single clock; all state on its rising edge.
- `reset_i` in 1: asynchronous, active-low reset; 0 = reset asserted.
- `valid_i` in `els_p`: per-channel input valid.
- `data_i` in `els_p`×`data_width_p`: per-channel input payload.
- `ready_o` out `els_p`: per-channel input accept; a transfer occurs when `valid_i[i]` & `ready_o[i]`.
- `link_v_o` out 1: tx flit valid.
- `link_data_o` out `link_width_p`: tx flit.
- `link_ready_i` in 1: tx flit accepted when `link_v_o` & `link_ready_i`.
- `link_v_i` in 1: rx flit valid.
- `link_data_i` in `link_width_p`: rx flit.
- `link_ready_o` out 1: rx flit accept.
- `valid_o` out `els_p`: per-channel output valid.
- `data_o` out `els_p`×`data_width_p`: per-channel output payload.
- `yumi_i` in `els_p`: per-channel output consume; legal only while `valid_o[i]`.
- `err_o` out 1: sticky flag, set on receipt of an out-of-range channel id.

## Operation

**Tx FSM (TX_IDLE, TX_HDR, TX_BODY)**
- **TX_IDLE:**
  - The round-robin arbiter grants the first `i` with `valid_i[i]=1`, scanning from `last_grant+1` and wrapping.
  - `ready_o[grant]=1` combinationally; all other `ready_o` bits are 0.
  - On transfer: capture `data_i[grant]` zero-extended to `num_flits_lp*link_width_p` bits, capture the id, set `last_grant`=grant, go to TX_HDR.
  - `ready_o` is all-zero in TX_HDR and TX_BODY.
- **TX_HDR:**
  - `link_v_o=1`; `link_data_o` = channel id in the low `id_width_lp` bits, upper bits 0.
  - On accept, go to TX_BODY with flit count = 0.
- **TX_BODY:**
  - `link_v_o=1`; `link_data_o` = flit[count], least-significant slice first.
  - On accept, count++. Accepting the last flit returns the FSM to TX_IDLE.
  - The last flit's bits above `data_width_p` are 0.
- **Hold rule:** while `link_v_o=1` and `link_ready_i=0`, `link_data_o` is held stable.

**Rx FSM (RX_HDR, RX_BODY)**
- **RX_HDR:**
  - `link_ready_o=1`.
  - On flit, latch id = low `id_width_lp` bits and go to RX_BODY with count = 0.
  - If id ≥ `els_p`, also set `err_o` and mark the message as drop.
- **RX_BODY:**
  - `link_ready_o=1` for non-last flits. Each accepted flit is shifted into the assembly register.
  - Last flit: `link_ready_o` = drop | ~`valid_o[id]` | `yumi_i[id]`.
  - On acceptance of the last flit:
    - If not drop: write the assembled low `data_width_p` bits to `data_o[id]` and set `valid_o[id]`.
    - In all cases, go to RX_HDR.
- **Output buffers:** `valid_o[i]` clears on `yumi_i[i]`. A same-cycle yumi and refill leaves `valid_o` at 1 with the new data.
- **Head-of-line blocking:** a stalled last flit blocks the link for all channels. This is required behaviour.

## Timing

- **Reset values:** `ready_o`=0, `link_v_o`=0, `link_ready_o`=0, `valid_o`=0, `err_o`=0, `last_grant`=`els_p`-1 (channel 0 has first priority), both FSMs in their idle/header states.
- **Tx throughput:** with `link_ready_i` held high, TX_IDLE, TX_HDR and TX_BODY take 1, 1 and `num_flits_lp` cycles, so one message is sent per `num_flits_lp`+2 cycles.
- **Loopback latency:** with no stalls, `valid_i` accepted at cycle 0 gives `valid_o` high at cycle `num_flits_lp`+2.
- **Reset mid-message:** assertion clears all state immediately and asynchronously; any partial message is discarded. Both link ends must be reset together.
- **`err_o`:** clears only on reset.

## Test plan

Bench configuration: `data_width_p`=32, `link_width_p`=8, `els_p`=3, so `num_flits_lp`=4. Tx is looped to rx unless stated.

1. **Single message.** `data_i[1]`=0xDEADBEEF with `valid_i[1]` pulsed at cycle 0. Required link sequence: 0x01, 0xEF, 0xBE, 0xAD, 0xDE on cycles 1–5. `valid_o[1]`=1 at cycle 6 with `data_o[1]`=0xDEADBEEF.
2. **Round-robin.** All three `valid_i` held high and yumis always high. Required grant order 0, 1, 2, 0, 1, 2, with one accept every 6 cycles.
3. **Tx backpressure.** `link_ready_i`=0 for 3 cycles on the 0xBE flit. The flit is held stable, and the output payload is intact with a 3-cycle added latency.
4. **Rx full.** `valid_o[2]`=1 and `yumi_i[2]`=0, then a second message to ch2 arrives. `link_ready_o`=0 on its last flit until `yumi_i[2]`; a queued ch0 message is delayed behind it.
5. **Bad id.** Inject header 0x03 plus 4 flits directly on the rx side. `err_o`=1 and stays 1, no `valid_o` bit rises, and the next valid message is delivered correctly.
6. **Reset mid-body.** Assert `reset_i` low during the second data flit. All outputs go to 0 immediately; after release, a ch0 message carrying 0x12345678 is delivered correctly.
